// File: rtl/pc_stack_unit.sv
// rtl/pc_stack_unit.sv - program counter, return-address stack and halt state
module pc_stack_unit #(
    parameter int ADDR_W   = 8,
    parameter int DEPTH    = 8,
    parameter int RESET_PC = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       write_pc,
    input  logic [2:0]                 branch,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       add_pc,
    input  logic                       brfl_control,
    input  logic                       brfl_flag,
    input  logic [ADDR_W-1:0]          reg_target,
    input  logic [ADDR_W-1:0]          imm_target,
    output logic [ADDR_W-1:0]          pc,
    output logic                       halted,
    output logic [$clog2(DEPTH):0]     stack_depth,
    output logic                       stack_overflow,
    output logic                       stack_underflow
);

    localparam int SW = $clog2(DEPTH);
    localparam int DW = SW + 1;

    localparam logic [2:0] BR_JR   = 3'b001;
    localparam logic [2:0] BR_HALT = 3'b011;
    localparam logic [2:0] BR_JPC  = 3'b100;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DW-1:0]     depth_q, depth_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              do_push;

    logic [ADDR_W-1:0] stack_mem [DEPTH];

    logic              full;
    logic              empty;
    logic [SW-1:0]     push_idx;
    logic [SW-1:0]     top_idx;
    logic [ADDR_W-1:0] top_entry;
    logic [ADDR_W-1:0] pc_inc;

    // Derived stack pointers; the index truncations are exact because DEPTH is a power of two
    always_comb begin
        full      = (depth_q == DW'(DEPTH));
        empty     = (depth_q == '0);
        push_idx  = SW'(depth_q);
        top_idx   = SW'(depth_q - DW'(1));
        top_entry = stack_mem[top_idx];
        pc_inc    = pc_q + ADDR_W'(1);
    end

    // Next-state decode: push/pop first, then conditional branch, then the branch field
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        depth_d = depth_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        do_push = 1'b0;
        if (state_q == ST_RUN && write_pc) begin
            if (push && pop) begin
                pc_d = pc_inc;
            end else if (push) begin
                if (!full) begin
                    do_push = 1'b1;
                    depth_d = depth_q + DW'(1);
                    pc_d    = imm_target;
                end else begin
                    ovf_d = 1'b1;
                    pc_d  = pc_inc;
                end
            end else if (pop) begin
                if (!empty) begin
                    depth_d = depth_q - DW'(1);
                    pc_d    = top_entry + ADDR_W'(add_pc);
                end else begin
                    unf_d = 1'b1;
                    pc_d  = pc_inc;
                end
            end else if (brfl_control) begin
                pc_d = brfl_flag ? imm_target : pc_inc;
            end else begin
                case (branch)
                    BR_JR:   pc_d = reg_target;
                    BR_JPC:  pc_d = imm_target;
                    BR_HALT: state_d = ST_HALT;
                    default: pc_d = pc_inc;
                endcase
            end
        end
    end

    // Architectural state register; reset overrides any commit on the same edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            pc_q    <= ADDR_W'(RESET_PC);
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Stack storage; entries are never cleared, and a push under reset is suppressed
    always_ff @(posedge clk) begin
        if (rst_n && do_push) begin
            stack_mem[push_idx] <= pc_q;
        end
    end

    assign pc              = pc_q;
    assign halted          = (state_q == ST_HALT);
    assign stack_depth     = depth_q;
    assign stack_overflow  = ovf_q;
    assign stack_underflow = unf_q;

endmodule

// File: tb/tb_pc_stack_unit.sv
// tb/tb_pc_stack_unit.sv - directed self-checking bench for pc_stack_unit
module tb_pc_stack_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       write_pc = 1'b0;
    logic [2:0] branch = 3'b000;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic       add_pc = 1'b0;
    logic       brfl_control = 1'b0;
    logic       brfl_flag = 1'b0;
    logic [7:0] reg_target = 8'h00;
    logic [7:0] imm_target = 8'h00;
    logic [7:0] pc;
    logic       halted;
    logic [3:0] stack_depth;
    logic       stack_overflow;
    logic       stack_underflow;

    int vectors = 0;
    int miscompares = 0;

    pc_stack_unit #(.ADDR_W(8), .DEPTH(8), .RESET_PC(0)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .write_pc(write_pc),
        .branch(branch),
        .push(push),
        .pop(pop),
        .add_pc(add_pc),
        .brfl_control(brfl_control),
        .brfl_flag(brfl_flag),
        .reg_target(reg_target),
        .imm_target(imm_target),
        .pc(pc),
        .halted(halted),
        .stack_depth(stack_depth),
        .stack_overflow(stack_overflow),
        .stack_underflow(stack_underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [7:0] e_pc, input logic e_halt,
                               input logic [3:0] e_depth, input logic e_ovf, input logic e_unf);
        check({tag, ".pc"}, pc, e_pc);
        check({tag, ".halted"}, {7'b0, halted}, {7'b0, e_halt});
        check({tag, ".depth"}, {4'b0, stack_depth}, {4'b0, e_depth});
        check({tag, ".ovf"}, {7'b0, stack_overflow}, {7'b0, e_ovf});
        check({tag, ".unf"}, {7'b0, stack_underflow}, {7'b0, e_unf});
    endtask

    task automatic clear_inputs();
        write_pc = 1'b0; branch = 3'b000; push = 1'b0; pop = 1'b0; add_pc = 1'b0;
        brfl_control = 1'b0; brfl_flag = 1'b0; reg_target = 8'h00; imm_target = 8'h00;
    endtask

    task automatic commit(input logic [2:0] br, input logic psh, input logic pp, input logic ap,
                          input logic bc, input logic bf, input logic [7:0] rt, input logic [7:0] it);
        branch = br; push = psh; pop = pp; add_pc = ap;
        brfl_control = bc; brfl_flag = bf; reg_target = rt; imm_target = it;
        write_pc = 1'b1;
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic seq();                      commit(3'b000, 0, 0, 0, 0, 0, 8'h00, 8'h00); endtask
    task automatic jpc(input logic [7:0] t);   commit(3'b100, 0, 0, 0, 0, 0, 8'h00, t);     endtask
    task automatic call(input logic [7:0] t);  commit(3'b010, 1, 0, 0, 0, 0, 8'h00, t);     endtask
    task automatic ret(input logic ap);        commit(3'b000, 0, 1, ap, 0, 0, 8'h00, 8'h00); endtask

    initial begin
        logic [7:0] exp_pc;

        // reset state
        clear_inputs();
        do_reset();
        check_state("reset", 8'h00, 0, 0, 0, 0);

        // sequential commits
        seq(); check("seq1.pc", pc, 8'h01);
        seq(); check("seq2.pc", pc, 8'h02);
        seq(); check_state("seq3", 8'h03, 0, 0, 0, 0);

        // write_pc low: nothing changes
        branch = 3'b100; imm_target = 8'h99;
        @(posedge clk); #1;
        clear_inputs();
        check("nocommit.pc", pc, 8'h03);

        // call / ret with add_pc
        jpc(8'h05); check("jpc5.pc", pc, 8'h05);
        call(8'h40); check_state("call40", 8'h40, 0, 1, 0, 0);
        ret(1'b1); check_state("ret_add", 8'h06, 0, 0, 0, 0);

        // push+pop together acts as seq
        commit(3'b010, 1, 1, 0, 0, 0, 8'h00, 8'h40);
        check_state("pushpop", 8'h07, 0, 0, 0, 0);

        // fill the stack: pushes 0x10..0x17
        jpc(8'h10);
        for (int i = 0; i < 8; i++) begin
            call(8'h11 + 8'(i));
        end
        check_state("fill", 8'h18, 0, 8, 0, 0);

        // overflow: call not taken
        jpc(8'h20);
        call(8'h80);
        check_state("ovf", 8'h21, 0, 8, 1, 0);

        // drain with alternating add_pc
        for (int i = 0; i < 8; i++) begin
            ret(i[0]);
            exp_pc = 8'h17 - 8'(i) + 8'(i[0]);
            check("drain.pc", pc, exp_pc);
            check("drain.depth", {4'b0, stack_depth}, 8'(7 - i));
        end

        // underflow: last pop was 0x10 with add_pc=1 -> 0x11, now 0x12
        ret(1'b1);
        check_state("unf", 8'h12, 0, 0, 1, 1);

        // flags are sticky across further commits
        seq();
        check_state("sticky", 8'h13, 0, 0, 1, 1);

        // conditional branch, jr, wrap
        do_reset();
        check_state("reset2", 8'h00, 0, 0, 0, 0);
        jpc(8'h03);
        commit(3'b000, 0, 0, 0, 1, 0, 8'h00, 8'h10); check("brfl_nt.pc", pc, 8'h04);
        commit(3'b000, 0, 0, 0, 1, 1, 8'h00, 8'h10); check("brfl_t.pc", pc, 8'h10);
        commit(3'b001, 0, 0, 0, 0, 0, 8'h33, 8'h44); check("jr.pc", pc, 8'h33);
        jpc(8'hFF); seq(); check("wrap.pc", pc, 8'h00);
        commit(3'b101, 0, 0, 0, 0, 0, 8'h55, 8'h66); check("br101.pc", pc, 8'h01);
        commit(3'b010, 0, 0, 0, 0, 0, 8'h55, 8'h66);
        check_state("br010_nopush", 8'h02, 0, 0, 0, 0);

        // popped all-ones + 1 wraps to 0
        jpc(8'hFF); call(8'h50); ret(1'b1);
        check_state("popwrap", 8'h00, 0, 0, 0, 0);

        // halt freezes everything
        jpc(8'h07);
        commit(3'b011, 0, 0, 0, 0, 0, 8'h00, 8'h00);
        check_state("halt", 8'h07, 1, 0, 0, 0);
        call(8'h40);
        check_state("halt_call", 8'h07, 1, 0, 0, 0);
        jpc(8'h22);
        commit(3'b000, 0, 1, 0, 0, 0, 8'h00, 8'h00);
        check_state("halt_jpc_pop", 8'h07, 1, 0, 0, 0);
        do_reset();
        check_state("halt_reset", 8'h00, 0, 0, 0, 0);

        // reset on the same edge as a push commit
        call(8'h30); call(8'h31); call(8'h32);
        check_state("depth3", 8'h32, 0, 3, 0, 0);
        rst_n = 1'b0;
        branch = 3'b010; push = 1'b1; imm_target = 8'h77; write_pc = 1'b1;
        @(posedge clk); #1;
        clear_inputs();
        rst_n = 1'b1;
        check_state("rst_push", 8'h00, 0, 0, 0, 0);
        ret(1'b0);
        check_state("rst_push_pop", 8'h01, 0, 0, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pc_stack_unit.md
Name: pc_stack_unit

Overview:
- Program-counter and return-address-stack stage that sits directly downstream of the microprogrammed control unit.
- Consumes the per-instruction control bundle: branch code, push/pop, add_pc, brfl_control and the write_pc commit strobe.
- Produces the next instruction address for instruction fetch.
- Owns the call/return stack and the halt state.

Parameters:
ADDR_W, 8, width of pc and of all target/stack entries
DEPTH, 8, number of return-stack entries (power of two, >=2)
RESET_PC, 0, pc value after reset

Ports:
clk  in  1  clock; all state changes on rising edge
rst_n  in  1  synchronous active-low reset
write_pc  in  1  commit strobe; pc/stack update only on an edge where write_pc=1
branch  in  3  000 seq, 001 jr, 010 call, 011 halt, 100 jpc, others treated as seq
push  in  1  call stack push request
pop  in  1  return stack pop request
add_pc  in  1  on pop: return to popped address +1
brfl_control  in  1  conditional branch instruction
brfl_flag  in  1  ALU flag; brfl taken when 1
reg_target  in  ADDR_W  register-sourced target (jr)
imm_target  in  ADDR_W  immediate target (jpc, call, brfl)
pc  out  ADDR_W  current instruction address
halted  out  1  core halted
stack_depth  out  log2(DEPTH)+1  entries currently on stack
stack_overflow  out  1  sticky: push attempted when full
stack_underflow  out  1  sticky: pop attempted when empty

Behaviour:
- Reset (rst_n=0 at rising edge; overrides everything, including mid-instruction):
  - pc=RESET_PC, halted=0, stack_depth=0, both sticky flags=0.
  - Stack contents are don't-care.
- FSM states RUN and HALT:
  - RUN -> HALT on a commit with branch=011; pc holds its value on that commit.
  - HALT ignores all commits: pc, stack and flags frozen.
  - Only reset leaves HALT.
- In RUN, on an edge with write_pc=0, nothing changes.
- In RUN, on an edge with write_pc=1, the next state is chosen by the first matching rule:
  1. push=1 and pop=1: illegal combination. Treated as seq (pc+1); no stack change; no flag set.
  2. push=1, stack not full: stack[depth]<=pc; depth+1; pc<=imm_target.
  3. push=1, stack full: stack_overflow<=1; no push; pc<=pc+1, i.e. the call is not taken.
  4. pop=1, stack not empty: depth-1; pc<=stack[depth-1] + (add_pc?1:0).
  5. pop=1, stack empty: stack_underflow<=1; pc<=pc+1.
  6. brfl_control=1: pc<=brfl_flag ? imm_target : pc+1.
  7. branch=001: pc<=reg_target.
  8. branch=100: pc<=imm_target.
  9. branch=011: enter HALT; pc unchanged.
  10. Otherwise (000, 101, 110, 111): pc<=pc+1.
- Push/pop take priority over the branch field. The control unit drives branch=010 together with push=1 for call; the branch field alone never pushes.
- Latency: pc, stack_depth and flags are visible one cycle after the committing edge. The committing edge always uses the old pc value.
- Arithmetic:
  - All pc arithmetic is modulo 2^ADDR_W: pc=2^ADDR_W-1 with seq gives 0.
  - A popped entry of all-ones with add_pc=1 wraps to 0.
- Stack is LIFO:
  - full when stack_depth==DEPTH; empty when stack_depth==0.
  - Stack entries are not cleared on pop.
- Sticky flags clear only on reset.
- write_pc held high for several consecutive cycles: each cycle is a separate commit. This is legal and is not filtered.

Test Plan:
- Reset then 3 seq commits (branch=000) -> pc 0,1,2,3; halted=0; depth=0.
- pc=5: commit call (push=1, branch=010, imm_target=0x40) -> pc=0x40, depth=1. Then commit ret (pop=1, add_pc=1) -> pc=6, depth=0.
- With DEPTH=8, perform 8 calls, then a 9th call with imm_target=0x80 from pc=0x20 -> pc=0x21, stack_overflow=1, depth=8. Then 8 rets -> depth 0. A further ret -> stack_underflow=1 and pc increments.
- brfl_control=1, imm_target=0x10 at pc=3: brfl_flag=0 -> pc=4; at pc=4 with brfl_flag=1 -> pc=0x10. Also jr with reg_target=0x33 -> pc=0x33; pc=0xFF with seq -> pc=0x00.
- At pc=7, commit branch=011 -> halted=1, pc stays 7. Further commits (call, jpc) change nothing. Assert rst_n=0 for one edge -> pc=RESET_PC, halted=0, flags cleared.
- Reset mid-call: depth=3, assert rst_n=0 on the same edge as a push commit -> depth=0, pc=RESET_PC, and no push is recorded.
